// File: rtl/cve2_pkg.sv
// Shared types for the RVFI trace packer: the captured retirement record and serialiser states.
package cve2_pkg;

    localparam logic [3:0] TraceSync = 4'hA;

    typedef struct packed {
        logic        drop;
        logic        trap;
        logic        intr;
        logic [1:0]  mode;
        logic [4:0]  rd_addr;
        logic [3:0]  wmask;
        logic [3:0]  rmask;
        logic [7:0]  order;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
    } trace_rec_t;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PC,
        INSN,
        RDW,
        MADDR
    } trace_state_e;

    function automatic logic rec_has_rd(input trace_rec_t r);
        return r.rd_addr != 5'd0;
    endfunction

    function automatic logic rec_has_mem(input trace_rec_t r);
        return |(r.rmask | r.wmask);
    endfunction

    function automatic logic [31:0] rec_hdr(input trace_rec_t r);
        return {TraceSync, r.drop, r.trap, r.intr, r.mode, r.rd_addr,
                rec_has_rd(r), rec_has_mem(r), r.wmask, r.rmask, r.order};
    endfunction

endpackage

// File: rtl/cve2_trace_fifo.sv
// Depth-entry record FIFO; exposes both the head and the entry behind it so the
// serialiser can start the following packet in the same cycle the head is popped.
module cve2_trace_fifo
    import cve2_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  trace_rec_t               wdata_i,
    input  logic                     pop_i,
    output trace_rec_t               head_o,
    output trace_rec_t               next_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned AW = $clog2(Depth);

    logic [AW:0]   wptr_q, rptr_q;
    logic [AW-1:0] rd_nxt;
    trace_rec_t    mem_q [Depth];

    assign full_o  = (wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}};
    assign empty_o = wptr_q == rptr_q;
    assign count_o = wptr_q - rptr_q;
    assign rd_nxt  = rptr_q[AW-1:0] + AW'(1);
    assign head_o  = mem_q[rptr_q[AW-1:0]];
    assign next_o  = mem_q[rd_nxt];

    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i && !full_o) begin
                wptr_q <= wptr_q + (AW+1)'(1);
            end
            if (pop_i && !empty_o) begin
                rptr_q <= rptr_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/cve2_rvfi_trace_packer.sv
// Captures RVFI retirements into a FIFO and serialises each as a 3-5 word packet
// on a valid/ready stream; overflowing records are dropped, counted and flagged.
module cve2_rvfi_trace_packer
    import cve2_pkg::*;
#(
    parameter int unsigned Depth    = 4,
    parameter int unsigned DropCntW = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic                clr_drops_i,
    input  logic                rvfi_valid,
    input  logic [63:0]         rvfi_order,
    input  logic [31:0]         rvfi_insn,
    input  logic                rvfi_trap,
    input  logic                rvfi_intr,
    input  logic [1:0]          rvfi_mode,
    input  logic [31:0]         rvfi_pc_rdata,
    input  logic [4:0]          rvfi_rd_addr,
    input  logic [31:0]         rvfi_rd_wdata,
    input  logic [31:0]         rvfi_mem_addr,
    input  logic [3:0]          rvfi_mem_rmask,
    input  logic [3:0]          rvfi_mem_wmask,
    output logic                trace_valid_o,
    input  logic                trace_ready_i,
    output logic [31:0]         trace_data_o,
    output logic                trace_last_o,
    output logic [DropCntW-1:0] drop_cnt_o,
    output logic                fifo_empty_o
);

    localparam int unsigned CntW = $clog2(Depth) + 1;

    trace_state_e  state_q;
    trace_rec_t    in_rec, head, second, nxt_rec;
    logic          fifo_full, fifo_empty, push, drop, hs, pop, nxt_avail;
    logic          drop_pending_q;
    logic [CntW-1:0] fifo_count;
    logic          unused_order;

    assign unused_order = ^rvfi_order[63:8];

    assign in_rec = '{
        drop:     drop_pending_q,
        trap:     rvfi_trap,
        intr:     rvfi_intr,
        mode:     rvfi_mode,
        rd_addr:  rvfi_rd_addr,
        wmask:    rvfi_mem_wmask,
        rmask:    rvfi_mem_rmask,
        order:    rvfi_order[7:0],
        pc:       rvfi_pc_rdata,
        insn:     rvfi_insn,
        rd_wdata: rvfi_rd_wdata,
        mem_addr: rvfi_mem_addr
    };

    assign push = rvfi_valid && enable_i && !fifo_full;
    assign drop = rvfi_valid && enable_i && fifo_full;
    assign hs   = trace_valid_o && trace_ready_i;
    assign pop  = hs && trace_last_o;

    cve2_trace_fifo #(.Depth(Depth)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .wdata_i (in_rec),
        .pop_i   (pop),
        .head_o  (head),
        .next_o  (second),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // The in-flight record stays at the FIFO head until its last word, so the
    // following record is either the second entry or a record arriving right now.
    always_comb begin
        nxt_avail = 1'b0;
        nxt_rec   = in_rec;
        if (state_q == IDLE) begin
            nxt_avail = !fifo_empty || push;
            nxt_rec   = fifo_empty ? in_rec : head;
        end else begin
            nxt_avail = (fifo_count >= CntW'(2)) || push;
            nxt_rec   = (fifo_count >= CntW'(2)) ? second : in_rec;
        end
    end

    // state | meaning
    // IDLE  | nothing presented;  HDR/PC/INSN/RDW/MADDR | that word is on trace_data_o
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            trace_valid_o <= 1'b0;
            trace_data_o  <= '0;
            trace_last_o  <= 1'b0;
        end else if (state_q == IDLE || hs) begin
            if (state_q == IDLE || trace_last_o) begin
                if (nxt_avail) begin
                    state_q       <= HDR;
                    trace_valid_o <= 1'b1;
                    trace_data_o  <= rec_hdr(nxt_rec);
                    trace_last_o  <= 1'b0;
                end else begin
                    state_q       <= IDLE;
                    trace_valid_o <= 1'b0;
                    trace_data_o  <= '0;
                    trace_last_o  <= 1'b0;
                end
            end else begin
                unique case (state_q)
                    HDR: begin
                        state_q      <= PC;
                        trace_data_o <= head.pc;
                        trace_last_o <= 1'b0;
                    end
                    PC: begin
                        state_q      <= INSN;
                        trace_data_o <= head.insn;
                        trace_last_o <= !rec_has_rd(head) && !rec_has_mem(head);
                    end
                    INSN: begin
                        if (rec_has_rd(head)) begin
                            state_q      <= RDW;
                            trace_data_o <= head.rd_wdata;
                            trace_last_o <= !rec_has_mem(head);
                        end else begin
                            state_q      <= MADDR;
                            trace_data_o <= head.mem_addr;
                            trace_last_o <= 1'b1;
                        end
                    end
                    RDW: begin
                        state_q      <= MADDR;
                        trace_data_o <= head.mem_addr;
                        trace_last_o <= 1'b1;
                    end
                    default: begin
                        state_q       <= IDLE;
                        trace_valid_o <= 1'b0;
                        trace_data_o  <= '0;
                        trace_last_o  <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_o     <= '0;
            drop_pending_q <= 1'b0;
        end else begin
            if (clr_drops_i) begin
                drop_cnt_o <= drop ? DropCntW'(1) : '0;
            end else if (drop && drop_cnt_o != {DropCntW{1'b1}}) begin
                drop_cnt_o <= drop_cnt_o + DropCntW'(1);
            end
            if (push) begin
                drop_pending_q <= 1'b0;
            end else if (drop) begin
                drop_pending_q <= 1'b1;
            end
        end
    end

    assign fifo_empty_o = fifo_empty && (state_q == IDLE);

endmodule

// File: tb/tb_cve2_rvfi_trace_packer.sv
// Scoreboard bench for the RVFI trace packer: expected packet words are queued as
// records are captured and compared word by word on every stream handshake.
module tb_cve2_rvfi_trace_packer;

    localparam int Depth    = 4;
    localparam int DropCntW = 4;

    logic                clk_i = 1'b0;
    logic                rst_ni = 1'b0;
    logic                enable_i = 1'b1;
    logic                clr_drops_i = 1'b0;
    logic                rvfi_valid = 1'b0;
    logic [63:0]         rvfi_order = '0;
    logic [31:0]         rvfi_insn = '0;
    logic                rvfi_trap = 1'b0;
    logic                rvfi_intr = 1'b0;
    logic [1:0]          rvfi_mode = '0;
    logic [31:0]         rvfi_pc_rdata = '0;
    logic [4:0]          rvfi_rd_addr = '0;
    logic [31:0]         rvfi_rd_wdata = '0;
    logic [31:0]         rvfi_mem_addr = '0;
    logic [3:0]          rvfi_mem_rmask = '0;
    logic [3:0]          rvfi_mem_wmask = '0;
    logic                trace_valid_o;
    logic                trace_ready_i = 1'b0;
    logic [31:0]         trace_data_o;
    logic                trace_last_o;
    logic [DropCntW-1:0] drop_cnt_o;
    logic                fifo_empty_o;

    cve2_rvfi_trace_packer #(.Depth(Depth), .DropCntW(DropCntW)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .enable_i       (enable_i),
        .clr_drops_i    (clr_drops_i),
        .rvfi_valid     (rvfi_valid),
        .rvfi_order     (rvfi_order),
        .rvfi_insn      (rvfi_insn),
        .rvfi_trap      (rvfi_trap),
        .rvfi_intr      (rvfi_intr),
        .rvfi_mode      (rvfi_mode),
        .rvfi_pc_rdata  (rvfi_pc_rdata),
        .rvfi_rd_addr   (rvfi_rd_addr),
        .rvfi_rd_wdata  (rvfi_rd_wdata),
        .rvfi_mem_addr  (rvfi_mem_addr),
        .rvfi_mem_rmask (rvfi_mem_rmask),
        .rvfi_mem_wmask (rvfi_mem_wmask),
        .trace_valid_o  (trace_valid_o),
        .trace_ready_i  (trace_ready_i),
        .trace_data_o   (trace_data_o),
        .trace_last_o   (trace_last_o),
        .drop_cnt_o     (drop_cnt_o),
        .fifo_empty_o   (fifo_empty_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [32:0] exp_q[$];
    logic [7:0]  ord = 8'h10;
    logic [31:0] last_hdr;
    logic        stall_q = 1'b0;
    logic [31:0] held_data;
    logic        held_last;
    logic        prev_last_hs = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] hdr_of(input logic d, input logic t, input logic it,
                                           input logic [1:0] m, input logic [4:0] rd,
                                           input logic [3:0] wm, input logic [3:0] rm,
                                           input logic [7:0] o);
        logic [31:0] h;
        h        = 32'hA000_0000;
        h[27]    = d;
        h[26]    = t;
        h[25]    = it;
        h[24:23] = m;
        h[22:18] = rd;
        h[17]    = (rd != 5'd0);
        h[16]    = |(rm | wm);
        h[15:12] = wm;
        h[11:8]  = rm;
        h[7:0]   = o;
        return h;
    endfunction

    // One-cycle retirement; expectations are queued only once the DUT has captured it.
    task automatic retire(input logic [31:0] pc, input logic [31:0] insn, input logic [4:0] rd,
                          input logic [31:0] wd, input logic [31:0] ma,
                          input logic [3:0] rm, input logic [3:0] wm,
                          input logic trap, input logic intr, input logic [1:0] mode,
                          input bit acc, input logic dropf);
        logic has_rd, has_mem;
        has_rd  = (rd != 5'd0);
        has_mem = (rm != 4'd0) || (wm != 4'd0);
        rvfi_valid     = 1'b1;
        rvfi_order     = {56'hABCDEF_0123_4567, ord};
        rvfi_pc_rdata  = pc;
        rvfi_insn      = insn;
        rvfi_rd_addr   = rd;
        rvfi_rd_wdata  = wd;
        rvfi_mem_addr  = ma;
        rvfi_mem_rmask = rm;
        rvfi_mem_wmask = wm;
        rvfi_trap      = trap;
        rvfi_intr      = intr;
        rvfi_mode      = mode;
        last_hdr = hdr_of(dropf, trap, intr, mode, rd, wm, rm, ord);
        @(posedge clk_i);
        if (acc) begin
            exp_q.push_back({1'b0, last_hdr});
            exp_q.push_back({1'b0, pc});
            exp_q.push_back({!has_rd && !has_mem, insn});
            if (has_rd) exp_q.push_back({!has_mem, wd});
            if (has_mem) exp_q.push_back({1'b1, ma});
        end
        ord = ord + 8'd1;
        #1 rvfi_valid = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || trace_valid_o) && n < max_cycles) begin
            @(negedge clk_i);
            n++;
        end
        check_eq("drain_done", {63'd0, (exp_q.size() == 0 && !trace_valid_o)}, 64'd1);
        @(posedge clk_i);
        #1;
    endtask

    always @(negedge clk_i) begin
        logic [32:0] e;
        if (!rst_ni) begin
            stall_q      = 1'b0;
            prev_last_hs = 1'b0;
        end else begin
            if (stall_q) begin
                check_eq("stall_valid", {63'd0, trace_valid_o}, 64'd1);
                check_eq("stall_data", {32'd0, trace_data_o}, {32'd0, held_data});
                check_eq("stall_last", {63'd0, trace_last_o}, {63'd0, held_last});
            end
            if (prev_last_hs && exp_q.size() != 0)
                check_eq("b2b_valid", {63'd0, trace_valid_o}, 64'd1);
            prev_last_hs = 1'b0;
            if (trace_valid_o && trace_ready_i) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_word", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("word", {32'd0, trace_data_o}, {32'd0, e[31:0]});
                    check_eq("last", {63'd0, trace_last_o}, {63'd0, e[32]});
                    prev_last_hs = trace_last_o;
                end
            end
            stall_q   = trace_valid_o && !trace_ready_i;
            held_data = trace_data_o;
            held_last = trace_last_o;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_valid", {63'd0, trace_valid_o}, 64'd0);
        check_eq("rst_data", {32'd0, trace_data_o}, 64'd0);
        check_eq("rst_last", {63'd0, trace_last_o}, 64'd0);
        check_eq("rst_drops", 64'(drop_cnt_o), 64'd0);
        check_eq("rst_empty", {63'd0, fifo_empty_o}, 64'd1);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // single retire with a destination register
        trace_ready_i = 1'b1;
        retire(32'h80, 32'h0050_0093, 5'd1, 32'h5, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
        check_eq("lat_valid", {63'd0, trace_valid_o}, 64'd1);
        check_eq("lat_hdr", {32'd0, trace_data_o}, {32'd0, last_hdr});
        check_eq("lat_empty", {63'd0, fifo_empty_o}, 64'd0);
        drain(20);

        // store under a 5-cycle stall
        trace_ready_i = 1'b0;
        retire(32'h104, 32'h0011_2023, 5'd0, 32'hFFFF, 32'h1000, 4'h0, 4'hF, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        repeat (5) @(posedge clk_i);
        #1;
        trace_ready_i = 1'b1;
        drain(20);

        // overflow burst: Depth accepted, three dropped
        trace_ready_i = 1'b0;
        for (int i = 0; i < Depth + 3; i++)
            retire(32'h200 + 32'(i * 4), 32'h1000_0013 | 32'(i), 5'(i), 32'hA000_0000 + 32'(i),
                   32'h2000 + 32'(i * 8), (i % 2 == 1) ? 4'h3 : 4'h0, (i == 2) ? 4'hC : 4'h0,
                   i == 3, i == 1, 2'(i), i < Depth, 1'b0);
        check_eq("burst_drops", 64'(drop_cnt_o), 64'd3);
        check_eq("burst_empty", {63'd0, fifo_empty_o}, 64'd0);
        trace_ready_i = 1'b1;
        drain(80);
        retire(32'h300, 32'h0000_0073, 5'd7, 32'h77, 32'h400, 4'h1, 4'h0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1);
        drain(20);

        // counter saturation and clear-with-drop
        clr_drops_i = 1'b1;
        @(posedge clk_i);
        #1 clr_drops_i = 1'b0;
        check_eq("clr_drops", 64'(drop_cnt_o), 64'd0);
        trace_ready_i = 1'b0;
        for (int i = 0; i < Depth; i++)
            retire(32'h500 + 32'(i * 4), 32'h2000_0013 + 32'(i), 5'(i + 3), 32'h55 + 32'(i), 32'h0,
                   4'h0, 4'h0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++)
            retire(32'h600, 32'h13, 5'd1, 32'h1, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        check_eq("cnt_max", 64'(drop_cnt_o), 64'd15);
        retire(32'h604, 32'h13, 5'd1, 32'h1, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        check_eq("cnt_sat", 64'(drop_cnt_o), 64'd15);
        clr_drops_i = 1'b1;
        retire(32'h608, 32'h13, 5'd1, 32'h1, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        clr_drops_i = 1'b0;
        check_eq("cnt_clr_drop", 64'(drop_cnt_o), 64'd1);
        trace_ready_i = 1'b1;
        drain(80);

        // back-to-back packets, then enable dropped mid-stream
        retire(32'h700, 32'h0030_0113, 5'd2, 32'h3, 32'h0, 4'h0, 4'h0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b1);
        retire(32'h704, 32'h0041_2183, 5'd3, 32'hCAFE, 32'h8000, 4'hF, 4'h0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0);
        enable_i = 1'b0;
        retire(32'h708, 32'h13, 5'd4, 32'h9, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        check_eq("en_off_drops", 64'(drop_cnt_o), 64'd1);
        drain(40);
        enable_i = 1'b1;
        check_eq("en_off_empty", {63'd0, fifo_empty_o}, 64'd1);

        // reset while the PC word is presented
        trace_ready_i = 1'b0;
        retire(32'h900, 32'h0010_0093, 5'd1, 32'h1, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
        trace_ready_i = 1'b1;
        @(posedge clk_i);
        #1 trace_ready_i = 1'b0;
        check_eq("mid_pc", {32'd0, trace_data_o}, 64'h900);
        rst_ni = 1'b0;
        #1;
        check_eq("mid_rst_valid", {63'd0, trace_valid_o}, 64'd0);
        check_eq("mid_rst_data", {32'd0, trace_data_o}, 64'd0);
        check_eq("mid_rst_last", {63'd0, trace_last_o}, 64'd0);
        check_eq("mid_rst_drops", 64'(drop_cnt_o), 64'd0);
        check_eq("mid_rst_empty", {63'd0, fifo_empty_o}, 64'd1);
        exp_q.delete();
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(posedge clk_i);
        #1 trace_ready_i = 1'b1;
        retire(32'hA00, 32'h0020_0093, 5'd1, 32'h2, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
        check_eq("post_rst_hdr", {32'd0, trace_data_o}, {32'd0, last_hdr});
        drain(20);
        check_eq("final_empty", {63'd0, fifo_empty_o}, 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
